modadd_pipe: RTL and testbench
==============================

// Module: modadd_pipe
// PURPOSE
// - Pipelined modular adder: C = (A + B) mod q, for A, B in [0, q).
// - Additive counterpart of the modular subtractor. Feeds butterfly/NTT datapaths
//   that need both operations with matching latency.
// - Adds a valid/ready handshake with full backpressure, so the block can sit
//   between stalling producers and consumers.
// PARAMETERS
// - LOGA    64  width of operand A
// - LOGB    64  width of operand B
// - LOGQ    64  width of modulus q and result C
// - LOGQH   47  number of significant high bits of q
// - FF_IN   1   input register stage present (0/1)
// - FF_ADD  1   register after the add/compare stage (0/1)
// - FF_OUT  1   output register stage present (0/1)
// - LAT     FF_IN+FF_ADD+FF_OUT  localparam; cycles from accept to out_valid when never stalled
// PORTS
// - clk        in   1     clock, rising edge
// - rst        in   1     asynchronous, active-low reset
// - in_valid   in   1     A/B/q carry a valid operation
// - in_ready   out  1     block accepts the operation this cycle
// - A          in   LOGA  operand A, < q
// - B          in   LOGB  operand B, < q
// - q          in   LOGQ  modulus; only q[LOGQ-1:LOGQ-LOGQH] and q[0] are used
// - out_valid  out  1     C is valid
// - out_ready  in   1     consumer takes C this cycle
// - C          out  LOGQ  result
// BEHAVIOUR
// - Effective modulus: qe = {q[LOGQ-1:LOGQ-LOGQH], (LOGQ-LOGQH-1)'b0, q[0]}.
//   All other q bits are ignored.
// - Arithmetic:
//   - S = A + B, LOGQ+1 bits, carry kept.
//   - D = S - {1'b0, qe}, LOGQ+2 bits.
//   - C = D[LOGQ+1] ? S[LOGQ-1:0] : D[LOGQ-1:0].
//   - Both candidates are computed in the ADD stage.
// - Transfer rules:
//   - Input transfer on in_valid & in_ready.
//   - Output transfer on out_valid & out_ready.
// - Per-stage valid bit vld[k]. A stage loads when it is empty or its contents
//   move downstream this cycle. Bubbles collapse.
// - in_ready = ~vld[0] | stage0_advances. It is combinational from out_ready
//   through the stall chain; there is no skid buffer.
// - When out_valid & ~out_ready:
//   - C stays stable.
//   - out_valid stays high.
//   - Upstream stages hold once they are full.
// - Ordering: results leave in strict acceptance order. No drops, no duplicates.
// - Stage count 0 (all FF_* = 0): purely combinational. out_valid = in_valid,
//   in_ready = out_ready.
// - Reset (rst low, async):
//   - All vld clear, so out_valid = 0.
//   - Data registers clear to 0, so C = 0.
//   - in_ready = 1 after reset.
//   - Mid-operation reset discards in-flight results, and no stale out_valid
//     appears after release.
// - Data registers load only on advance. Invalid stages do not toggle data (power).
// - Out-of-range operands (A or B >= qe): result undefined, no assertion in RTL.
// STRUCTURE
// - modop_pkg: function qe_expand(q, LOGQ, LOGQH), and the LAT computation helper
//   shared by modadd_pipe and the modular subtractor.
// - Sub-module pipe_slice #(W, EN): one register stage holding a valid bit and a
//   W-bit payload, with load/hold logic. EN=0 gives a passthrough.
//   Instantiated three times.
// TESTING
// - Single op, no stall:
//   - Stimulus: A=64'h010000000000000A, B=64'h1000000000000005, q=64'h111110000000000C.
//   - Required: C=64'h110000000000000F, out_valid exactly LAT cycles after acceptance.
// - Wrap:
//   - Stimulus: A=64'h11110FFFFFFFFFFF, B=2, q=64'h1111100000000000.
//   - Required: C=64'h0000000000000001.
// - Carry-out:
//   - Stimulus: A=B=64'hFFFFFFFFFFFE0000, q=64'hFFFFFFFFFFFE0001.
//   - Required: C=64'hFFFFFFFFFFFDFFFF.
// - Backpressure:
//   - Stimulus: stream 8 ops back-to-back with out_ready low for cycles 3..7.
//   - Required: in_ready falls once all LAT stages are full, C is held stable,
//     and all 8 results arrive in order with none lost.
// - Reset mid-stream:
//   - Stimulus: assert rst low with 2 ops in flight.
//   - Required: out_valid=0 and C=0 immediately; no result appears after release;
//     in_ready=1.
// - Random: 10k random A,B < qe with random in_valid/out_ready.
//   - Required: scoreboard matches a (A+B)%qe reference model.

Source files
------------

// File: rtl/modop_pkg.sv
// Shared helpers for the pipelined modular add/sub datapaths:
// effective-modulus expansion and pipeline latency.
package modop_pkg;

  localparam int QMAX = 128;

  function automatic logic [QMAX-1:0] qe_expand(
    input logic [QMAX-1:0] q,
    input int              logq,
    input int              logqh
  );
    logic [QMAX-1:0] r;
    r = '0;
    // keep the top logqh bits and bit 0, drop the rest
    for (int i = 0; i < QMAX; i++) begin
      if (i < logq && (i == 0 || i >= logq - logqh)) begin
        r[i] = q[i];
      end
    end
    return r;
  endfunction

  function automatic int lat_calc(
    input int ff_in,
    input int ff_add,
    input int ff_out
  );
    return ff_in + ff_add + ff_out;
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One optional register stage: valid bit plus W-bit payload
// with load/hold backpressure; EN=0 is a plain passthrough.
module pipe_slice #(
  parameter int W  = 1,
  parameter bit EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (EN) begin : g_reg
    logic         vld;
    logic [W-1:0] dat;
    logic         load;

    assign in_ready  = ~vld | out_ready;
    assign load      = in_valid & in_ready;
    assign out_valid = vld;
    assign out_data  = dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        dat <= '0;
      end else if (load) begin
        vld <= 1'b1;
        dat <= in_data;
      end else if (out_ready) begin
        vld <= 1'b0;
      end
    end
  end else begin : g_thru
    logic unused_clk;

    assign unused_clk = clk ^ rst_n;
    assign in_ready   = out_ready;
    assign out_valid  = in_valid;
    assign out_data   = in_data;
  end

endmodule

// File: rtl/modadd_pipe.sv
// Pipelined modular adder C = (A + B) mod qe with
// valid/ready handshake and full backpressure.
module modadd_pipe
  import modop_pkg::*;
#(
  parameter int LOGA   = 64,
  parameter int LOGB   = 64,
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter bit FF_IN  = 1'b1,
  parameter bit FF_ADD = 1'b1,
  parameter bit FF_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGA-1:0] A,
  input  logic [LOGB-1:0] B,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] C
);

  localparam int LAT = lat_calc(int'(FF_IN), int'(FF_ADD), int'(FF_OUT));
  localparam int W0  = LOGA + LOGB + LOGQ;

  logic [LOGQ-1:0] qe;
  logic [W0-1:0]   d0;
  logic [LOGA-1:0] a0;
  logic [LOGB-1:0] b0;
  logic [LOGQ-1:0] qe0;
  logic [LOGQ:0]   s;
  logic [LOGQ+1:0] d;
  logic [LOGQ-1:0] c1;
  logic [LOGQ-1:0] c2;
  logic            v0;
  logic            v1;
  logic            r0;
  logic            r1;
  logic            r2;
  logic            unused_d;

  assign qe = LOGQ'(qe_expand(QMAX'(q), LOGQ, LOGQH));

  pipe_slice #(.W(W0), .EN(FF_IN)) u_in (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (in_valid),
    .in_ready  (r0),
    .in_data   ({A, B, qe}),
    .out_valid (v0),
    .out_ready (r1),
    .out_data  (d0)
  );

  assign {a0, b0, qe0} = d0;

  // both candidates formed here; the borrow of D picks one
  assign s  = (LOGQ+1)'(a0) + (LOGQ+1)'(b0);
  assign d  = {1'b0, s} - {2'b00, qe0};
  assign c1 = d[LOGQ+1] ? s[LOGQ-1:0] : d[LOGQ-1:0];
  assign unused_d = d[LOGQ];

  pipe_slice #(.W(LOGQ), .EN(FF_ADD)) u_add (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (v0),
    .in_ready  (r1),
    .in_data   (c1),
    .out_valid (v1),
    .out_ready (r2),
    .out_data  (c2)
  );

  pipe_slice #(.W(LOGQ), .EN(FF_OUT)) u_out (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (v1),
    .in_ready  (r2),
    .in_data   (c2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (C)
  );

  if (LAT == 0) begin : g_comb
    assign in_ready = out_ready;
  end else begin : g_pipe
    assign in_ready = r0;
  end

endmodule

// File: tb/tb_modadd_pipe.sv
// Directed-vector and scoreboard bench for modadd_pipe.
// Default parameters: 64-bit operands, three stages.
module tb_modadd_pipe;

  localparam int LAT = 3;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic [63:0] q = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] C;

  int          vectors = 0;
  int          errs = 0;
  int          n_out = 0;
  logic [63:0] exp_in = '0;
  logic [63:0] sb[$];
  bit          prev_stall = 1'b0;
  logic [63:0] prev_c = '0;

  modadd_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tb_qe(input logic [63:0] qq);
    return {qq[63:17], 16'h0000, qq[0]};
  endfunction

  function automatic logic [63:0] tb_model(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] qq
  );
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return 64'(s % {1'b0, tb_qe(qq)});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // scoreboard / hold monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        vectors++;
        if (!out_valid || C !== prev_c) begin
          errs++;
          $display("FAIL hold: out_valid=%b C=%h, required 1 %h", out_valid, C, prev_c);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        n_out++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL spurious: C=%h with nothing outstanding", C);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          if (C !== e) begin
            errs++;
            $display("FAIL result: got %h, required %h", C, e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_in);
      prev_stall = out_valid && !out_ready;
      prev_c = C;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic cyc(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit acc;
    int n;
    A = v.a;
    B = v.b;
    q = v.q;
    exp_in = v.c;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cyc(acc);
      n++;
    end
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      cyc(acc);
      n++;
    end
    check($sformatf("latency[%0d]", idx), 64'(n), 64'(LAT));
    cyc(acc);
  endtask

  vec_t tv[8];

  initial begin
    bit          acc;
    int          base;
    int          accn;
    int          cycles;
    logic [63:0] qv;
    logic [63:0] av;
    logic [63:0] bv;

    tv[0] = '{64'h010000000000000A, 64'h1000000000000005, 64'h111110000000000C, 64'h110000000000000F};
    tv[1] = '{64'h11110FFFFFFFFFFF, 64'h0000000000000002, 64'h1111100000000000, 64'h0000000000000001};
    tv[2] = '{64'hFFFFFFFFFFFE0000, 64'hFFFFFFFFFFFE0000, 64'hFFFFFFFFFFFE0001, 64'hFFFFFFFFFFFDFFFF};
    tv[3] = '{64'h0000000000000000, 64'h0000000000000000, 64'h1111100000000000, 64'h0000000000000000};
    tv[4] = '{64'h11110FFFFFFFFFFF, 64'h0000000000000001, 64'h1111100000000000, 64'h0000000000000000};
    tv[5] = '{64'h11110FFFFFFFFFFF, 64'h11110FFFFFFFFFFF, 64'h1111100000000000, 64'h11110FFFFFFFFFFE};
    tv[6] = '{64'h1111100000000000, 64'h0000000000000000, 64'h111110000001FFFF, 64'h1111100000000000};
    tv[7] = '{64'h1111100000000000, 64'h0000000000000001, 64'h111110000001FFFF, 64'h0000000000000000};

    #3;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset C", C, 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(acc);

    for (int i = 0; i < 8; i++) run_vec(tv[i], i);

    // backpressure: 8 ops back to back, consumer stalls cycles 3..7
    base = n_out;
    q = 64'h1111100000000000;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 40; c++) begin
        in_valid = (k < 8);
        A = 64'h11110FFFFFFFFFF0 + 64'(k);
        B = 64'h10 + 64'(k);
        exp_in = 64'(2 * k);
        out_ready = !(c >= 3 && c <= 7);
        if (c == 4 || c == 5) begin
          #1;
          check($sformatf("stall in_ready c%0d", c), 64'(in_ready), 64'd0);
          check($sformatf("stall out_valid c%0d", c), 64'(out_valid), 64'd1);
        end
        cyc(acc);
        if (acc) k++;
      end
      in_valid = 1'b0;
    end
    check("backpressure count", 64'(n_out - base), 64'd8);
    check("backpressure drained", 64'(sb.size()), 64'd0);

    // reset with two ops in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      A = 64'(i + 1);
      B = 64'(i + 2);
      exp_in = 64'(2 * i + 3);
      cyc(acc);
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset C", C, 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = n_out;
    for (int i = 0; i < 10; i++) cyc(acc);
    check("post-reset outputs", 64'(n_out - base), 64'd0);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    // random stream against the reference model
    accn = 0;
    cycles = 0;
    qv = {$urandom | 32'h8000_0000, $urandom};
    av = {$urandom, $urandom} % tb_qe(qv);
    bv = {$urandom, $urandom} % tb_qe(qv);
    while (accn < 10000 && cycles < 60000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      A = av;
      B = bv;
      q = qv;
      exp_in = tb_model(av, bv, qv);
      cyc(acc);
      cycles++;
      if (acc) begin
        accn++;
        qv = {$urandom | 32'h8000_0000, $urandom};
        av = {$urandom, $urandom} % tb_qe(qv);
        bv = {$urandom, $urandom} % tb_qe(qv);
      end
    end
    check("random accepted", 64'(accn), 64'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(acc);
    check("random drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
